ts_lane_agreement: RTL and testbench

- Parametrised per-lane TS1/TS2 consecutive-match tracker plus link-width/lane-order resolver for the LTSSM Configuration and Recovery substates.
- Generalises the fixed 32-lane decoder consecutive-count path:
  - lane count, required match count and symbol width are parameters;
  - adds a selectable match mode, negotiated-width computation and lane-reversal detection.
- Sits between the per-lane OS decoders (upstream) and the LTSSM controller (downstream).

---
 rtl/ltssm_os_pkg.sv | 34 +++
 rtl/ts_lane_tracker.sv | 86 ++++++++
 rtl/ts_lane_agreement.sv | 141 ++++++++++++++
 tb/tb_ts_lane_agreement.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ltssm_os_pkg.sv
// Shared types and constants for the LTSSM ordered-set lane agreement logic.
package ltssm_os_pkg;

    typedef enum logic [1:0] {
        OS_NONE  = 2'd0,
        OS_TS1   = 2'd1,
        OS_TS2   = 2'd2,
        OS_OTHER = 2'd3
    } os_type_e;

    typedef enum logic [1:0] {
        MM_IDENT  = 2'd0,
        MM_PAD    = 2'd1,
        MM_NONPAD = 2'd2
    } match_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_EVAL  = 2'd2,
        ST_DONE  = 2'd3
    } agree_state_e;

    localparam logic [7:0] PAD_SYMBOL = 8'hF7;

    localparam logic [2:0] WC_NONE = 3'd0;
    localparam logic [2:0] WC_X1   = 3'd1;
    localparam logic [2:0] WC_X2   = 3'd2;
    localparam logic [2:0] WC_X4   = 3'd3;
    localparam logic [2:0] WC_X8   = 3'd4;
    localparam logic [2:0] WC_X16  = 3'd5;
    localparam logic [2:0] WC_X32  = 3'd6;

endpackage

// File: rtl/ts_lane_tracker.sv
// One lane's TS consecutive-match tracker: qualify, compare against the held
// {type, link, lane}, saturating count and registered lane_done.
module ts_lane_tracker
    import ltssm_os_pkg::*;
#(
    parameter int SYMBOL_WIDTH = 8,
    parameter int REQ_COUNT    = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    track_en,
    input  logic [1:0]              match_mode,
    input  logic [1:0]              expected_type,
    input  logic                    os_valid,
    input  logic [1:0]              os_type,
    input  logic [SYMBOL_WIDTH-1:0] link_num,
    input  logic [SYMBOL_WIDTH-1:0] lane_num,
    output logic                    lane_done,
    output logic [SYMBOL_WIDTH-1:0] held_link,
    output logic [SYMBOL_WIDTH-1:0] held_lane
);

    localparam logic [SYMBOL_WIDTH-1:0] PAD = SYMBOL_WIDTH'(PAD_SYMBOL);
    localparam logic [CNT_WIDTH-1:0]    REQ = CNT_WIDTH'(REQ_COUNT);

    logic [CNT_WIDTH-1:0] cnt, cnt_next;
    logic [1:0]           held_type;
    logic                 held_valid, valid_next;
    logic                 qualify, same, load;

    always_comb begin
        qualify = (os_type == expected_type);
        case (match_mode_e'(match_mode))
            MM_PAD:    qualify = qualify && (link_num == PAD) && (lane_num == PAD);
            MM_NONPAD: qualify = qualify && (link_num != PAD) && (lane_num != PAD);
            default:   qualify = qualify;
        endcase
        same = held_valid && (os_type == held_type) &&
               (link_num == held_link) && (lane_num == held_lane);
    end

    always_comb begin
        cnt_next   = cnt;
        valid_next = held_valid;
        load       = 1'b0;
        if (clr) begin
            cnt_next   = '0;
            valid_next = 1'b0;
        end else if (track_en && os_valid) begin
            if (!qualify) begin
                cnt_next   = '0;
                valid_next = 1'b0;
            end else if (same) begin
                if (cnt < REQ)
                    cnt_next = cnt + 1'b1;
            end else begin
                cnt_next   = CNT_WIDTH'(1);
                valid_next = 1'b1;
                load       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            held_valid <= 1'b0;
            held_type  <= '0;
            held_link  <= '0;
            held_lane  <= '0;
            lane_done  <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            held_valid <= valid_next;
            lane_done  <= (cnt_next >= REQ);
            if (load) begin
                held_type <= os_type;
                held_link <= link_num;
                held_lane <= lane_num;
            end
        end
    end

endmodule

// File: rtl/ts_lane_agreement.sv
// Per-lane TS1/TS2 agreement tracking plus link-width and lane-order resolution
// for the LTSSM Configuration/Recovery substates.
module ts_lane_agreement
    import ltssm_os_pkg::*;
#(
    parameter int NUM_LANES    = 32,
    parameter int SYMBOL_WIDTH = 8,
    parameter int REQ_COUNT    = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              clear,
    input  logic                              eval_req,
    input  logic [1:0]                        match_mode,
    input  logic [1:0]                        expected_type,
    input  logic [NUM_LANES-1:0]              rx_os_valid,
    input  logic [2*NUM_LANES-1:0]            rx_os_type,
    input  logic [SYMBOL_WIDTH*NUM_LANES-1:0] rx_link_num,
    input  logic [SYMBOL_WIDTH*NUM_LANES-1:0] rx_lane_num,
    output logic [NUM_LANES-1:0]              lane_done,
    output logic                              width_valid,
    output logic [2:0]                        width_code,
    output logic [SYMBOL_WIDTH-1:0]           agreed_link_num,
    output logic                              lane_reversed,
    output logic                              busy
);

    localparam int unsigned NL     = NUM_LANES;
    localparam int unsigned LOG2_N = $clog2(NUM_LANES);

    agree_state_e state, state_next;

    logic [SYMBOL_WIDTH-1:0] lane_link [NUM_LANES];
    logic [SYMBOL_WIDTH-1:0] lane_lane [NUM_LANES];
    logic                    track_en, lane_clr;

    assign track_en = (state == ST_TRACK);
    assign lane_clr = clear | start;
    assign busy     = (state == ST_TRACK) || (state == ST_EVAL);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        ts_lane_tracker #(
            .SYMBOL_WIDTH (SYMBOL_WIDTH),
            .REQ_COUNT    (REQ_COUNT),
            .CNT_WIDTH    (CNT_WIDTH)
        ) u_trk (
            .clk           (clk),
            .rst           (rst),
            .clr           (lane_clr),
            .track_en      (track_en),
            .match_mode    (match_mode),
            .expected_type (expected_type),
            .os_valid      (rx_os_valid[g]),
            .os_type       (rx_os_type[2*g +: 2]),
            .link_num      (rx_link_num[SYMBOL_WIDTH*g +: SYMBOL_WIDTH]),
            .lane_num      (rx_lane_num[SYMBOL_WIDTH*g +: SYMBOL_WIDTH]),
            .lane_done     (lane_done[g]),
            .held_link     (lane_link[g]),
            .held_lane     (lane_lane[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear)
            state_next = ST_IDLE;
        else if (start)
            state_next = ST_TRACK;
        else begin
            case (state)
                ST_TRACK: if (eval_req || (&lane_done)) state_next = ST_EVAL;
                ST_EVAL:  state_next = ST_DONE;
                default:  state_next = state;
            endcase
        end
    end

    // Widest power-of-two prefix of lanes that agrees wins; k indexes width NL>>k.
    logic       res_found, res_rev, all_ok, norm_ok, rev_ok;
    logic [2:0] res_code;

    always_comb begin
        res_found = 1'b0;
        res_rev   = 1'b0;
        res_code  = WC_NONE;
        all_ok    = 1'b0;
        norm_ok   = 1'b0;
        rev_ok    = 1'b0;
        for (int unsigned k = 0; k <= LOG2_N; k++) begin
            all_ok  = 1'b1;
            norm_ok = 1'b1;
            rev_ok  = 1'b1;
            for (int unsigned i = 0; i < NL; i++) begin
                if (i < (NL >> k)) begin
                    if (!lane_done[i])
                        all_ok = 1'b0;
                    if ((match_mode_e'(match_mode) != MM_PAD) && (lane_link[i] != lane_link[0]))
                        all_ok = 1'b0;
                    if (lane_lane[i] != SYMBOL_WIDTH'(i))
                        norm_ok = 1'b0;
                    if (lane_lane[i] != SYMBOL_WIDTH'((NL >> k) - 1 - i))
                        rev_ok = 1'b0;
                end
            end
            if ((match_mode_e'(match_mode) == MM_NONPAD) && !norm_ok && !rev_ok)
                all_ok = 1'b0;
            if (all_ok && !res_found) begin
                res_found = 1'b1;
                res_code  = WC_X1 + 3'(LOG2_N - k);
                res_rev   = (match_mode_e'(match_mode) == MM_NONPAD) && (k < LOG2_N) && !norm_ok;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            width_valid     <= 1'b0;
            width_code      <= WC_NONE;
            agreed_link_num <= '0;
            lane_reversed   <= 1'b0;
        end else if (clear || start) begin
            width_valid     <= 1'b0;
            width_code      <= WC_NONE;
            agreed_link_num <= '0;
            lane_reversed   <= 1'b0;
        end else if (state == ST_EVAL) begin
            width_valid     <= 1'b1;
            width_code      <= res_code;
            agreed_link_num <= res_found ? lane_link[0] : '0;
            lane_reversed   <= res_rev;
        end
    end

endmodule

// File: tb/tb_ts_lane_agreement.sv
// Directed self-checking bench for ts_lane_agreement with a 4-lane link.
module tb_ts_lane_agreement;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, clear, eval_req;
    logic [1:0]  match_mode, expected_type;
    logic [3:0]  rx_os_valid;
    logic [7:0]  rx_os_type;
    logic [31:0] rx_link_num, rx_lane_num;
    logic [3:0]  lane_done;
    logic        width_valid;
    logic [2:0]  width_code;
    logic [7:0]  agreed_link_num;
    logic        lane_reversed;
    logic        busy;

    logic [1:0]  tb_type [4];
    logic [7:0]  tb_link [4];
    logic [7:0]  tb_lane [4];

    int vec  = 0;
    int errs = 0;

    ts_lane_agreement #(
        .NUM_LANES    (4),
        .SYMBOL_WIDTH (8),
        .REQ_COUNT    (8),
        .CNT_WIDTH    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .clear           (clear),
        .eval_req        (eval_req),
        .match_mode      (match_mode),
        .expected_type   (expected_type),
        .rx_os_valid     (rx_os_valid),
        .rx_os_type      (rx_os_type),
        .rx_link_num     (rx_link_num),
        .rx_lane_num     (rx_lane_num),
        .lane_done       (lane_done),
        .width_valid     (width_valid),
        .width_code      (width_code),
        .agreed_link_num (agreed_link_num),
        .lane_reversed   (lane_reversed),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            rx_os_type[2*i +: 2]  = tb_type[i];
            rx_link_num[8*i +: 8] = tb_link[i];
            rx_lane_num[8*i +: 8] = tb_lane[i];
        end
        rx_os_valid = mask;
        tick();
        rx_os_valid = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_eval();
        eval_req = 1'b1;
        tick();
        eval_req = 1'b0;
    endtask

    task automatic set_lanes(input logic [7:0] link, input logic reversed);
        for (int i = 0; i < 4; i++) begin
            tb_type[i] = 2'd1;
            tb_link[i] = link;
            tb_lane[i] = reversed ? 8'(3 - i) : 8'(i);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        apply(4'hF);
        vec++; if (lane_done !== 4'h0) begin errs++; $display("FAIL reset_lane_done got %h exp 0", lane_done); end
        vec++; if (width_valid !== 1'b0) begin errs++; $display("FAIL reset_width_valid got %b exp 0", width_valid); end
        vec++; if (width_code !== 3'd0) begin errs++; $display("FAIL reset_width_code got %0d exp 0", width_code); end
        vec++; if (agreed_link_num !== 8'h00) begin errs++; $display("FAIL reset_link got %h exp 00", agreed_link_num); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b1;
        tick();
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_after_reset_busy got %b exp 0", busy); end
        apply(4'hF);
        vec++; if (lane_done !== 4'h0) begin errs++; $display("FAIL idle_ignores_os got %h exp 0", lane_done); end
    endtask

    task automatic test_normal();
        match_mode = 2'd2;
        expected_type = 2'd1;
        set_lanes(8'd5, 1'b0);
        pulse_start();
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL normal_busy got %b exp 1", busy); end
        for (int n = 0; n < 7; n++) apply(4'hF);
        vec++; if (lane_done !== 4'h0) begin errs++; $display("FAIL normal_done_at7 got %h exp 0", lane_done); end
        apply(4'hF);
        vec++; if (lane_done !== 4'hF) begin errs++; $display("FAIL normal_done_at8 got %h exp f", lane_done); end
        tick();
        vec++; if (width_valid !== 1'b0) begin errs++; $display("FAIL normal_valid_early got %b exp 0", width_valid); end
        tick();
        vec++; if (width_valid !== 1'b1) begin errs++; $display("FAIL normal_valid got %b exp 1", width_valid); end
        vec++; if (width_code !== 3'd3) begin errs++; $display("FAIL normal_code got %0d exp 3", width_code); end
        vec++; if (agreed_link_num !== 8'd5) begin errs++; $display("FAIL normal_link got %h exp 05", agreed_link_num); end
        vec++; if (lane_reversed !== 1'b0) begin errs++; $display("FAIL normal_rev got %b exp 0", lane_reversed); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL done_busy got %b exp 0", busy); end
    endtask

    task automatic test_reversed();
        set_lanes(8'd5, 1'b1);
        pulse_start();
        vec++; if (width_valid !== 1'b0) begin errs++; $display("FAIL start_drops_valid got %b exp 0", width_valid); end
        for (int n = 0; n < 8; n++) apply(4'hF);
        tick();
        tick();
        vec++; if (width_code !== 3'd3) begin errs++; $display("FAIL rev_code got %0d exp 3", width_code); end
        vec++; if (lane_reversed !== 1'b1) begin errs++; $display("FAIL rev_flag got %b exp 1", lane_reversed); end
    endtask

    task automatic test_partial_eval();
        set_lanes(8'd5, 1'b0);
        pulse_start();
        for (int n = 0; n < 4; n++) apply(4'b0111);
        tb_link[2] = 8'd6;
        apply(4'b0111);
        for (int n = 0; n < 3; n++) apply(4'b0011);
        vec++; if (lane_done !== 4'b0011) begin errs++; $display("FAIL partial_done got %b exp 0011", lane_done); end
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL partial_still_track got %b exp 1", busy); end
        pulse_eval();
        tick();
        vec++; if (width_valid !== 1'b1) begin errs++; $display("FAIL partial_valid got %b exp 1", width_valid); end
        vec++; if (width_code !== 3'd2) begin errs++; $display("FAIL partial_code got %0d exp 2", width_code); end
        vec++; if (agreed_link_num !== 8'd5) begin errs++; $display("FAIL partial_link got %h exp 05", agreed_link_num); end
    endtask

    task automatic test_pad_mode();
        match_mode = 2'd1;
        set_lanes(8'hF7, 1'b0);
        for (int i = 0; i < 3; i++) tb_lane[i] = 8'hF7;
        tb_link[3] = 8'd3;
        tb_lane[3] = 8'd3;
        pulse_start();
        for (int n = 0; n < 8; n++) apply(4'hF);
        vec++; if (lane_done !== 4'b0111) begin errs++; $display("FAIL pad_done got %b exp 0111", lane_done); end
        pulse_eval();
        tick();
        vec++; if (width_code !== 3'd2) begin errs++; $display("FAIL pad_code got %0d exp 2", width_code); end
        vec++; if (agreed_link_num !== 8'hF7) begin errs++; $display("FAIL pad_link got %h exp f7", agreed_link_num); end
        vec++; if (lane_reversed !== 1'b0) begin errs++; $display("FAIL pad_rev got %b exp 0", lane_reversed); end
    endtask

    task automatic test_saturate_restart();
        match_mode = 2'd0;
        set_lanes(8'd1, 1'b0);
        pulse_start();
        for (int n = 0; n < 20; n++) apply(4'b0111);
        vec++; if (lane_done !== 4'b0111) begin errs++; $display("FAIL sat_done got %b exp 0111", lane_done); end
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL sat_track got %b exp 1", busy); end
        pulse_start();
        vec++; if (lane_done !== 4'h0) begin errs++; $display("FAIL restart_clears got %h exp 0", lane_done); end
        for (int n = 0; n < 7; n++) apply(4'hF);
        vec++; if (lane_done !== 4'h0) begin errs++; $display("FAIL recount_at7 got %h exp 0", lane_done); end
        apply(4'hF);
        vec++; if (lane_done !== 4'hF) begin errs++; $display("FAIL recount_at8 got %h exp f", lane_done); end
        tick();
        tick();
        vec++; if (width_code !== 3'd3) begin errs++; $display("FAIL mode0_code got %0d exp 3", width_code); end
        vec++; if (lane_reversed !== 1'b0) begin errs++; $display("FAIL mode0_rev got %b exp 0", lane_reversed); end
    endtask

    task automatic test_clear_start();
        vec++; if (width_valid !== 1'b1) begin errs++; $display("FAIL pre_clear_valid got %b exp 1", width_valid); end
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        vec++; if (width_valid !== 1'b0) begin errs++; $display("FAIL clear_valid got %b exp 0", width_valid); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL clear_beats_start got %b exp 0", busy); end
        vec++; if (width_code !== 3'd0) begin errs++; $display("FAIL clear_code got %0d exp 0", width_code); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        for (int n = 0; n < 3; n++) apply(4'hF);
        tb_link[0] = 8'd9;
        apply(4'h1);
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy got %b exp 1", busy); end
        rst = 1'b0;
        #1;
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_reset_busy got %b exp 0", busy); end
        apply(4'hF);
        vec++; if (lane_done !== 4'h0) begin errs++; $display("FAIL mid_reset_done got %h exp 0", lane_done); end
        vec++; if (width_valid !== 1'b0) begin errs++; $display("FAIL mid_reset_valid got %b exp 0", width_valid); end
        rst = 1'b1;
        tick();
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL post_reset_idle got %b exp 0", busy); end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        eval_req = 1'b0;
        match_mode = 2'd0;
        expected_type = 2'd1;
        rx_os_valid = '0;
        rx_os_type = '0;
        rx_link_num = '0;
        rx_lane_num = '0;
        set_lanes(8'd0, 1'b0);
        test_reset();
        test_normal();
        test_reversed();
        test_partial_eval();
        test_pad_mode();
        test_saturate_restart();
        test_clear_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
